// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer: multi-cycle FETCH/EXEC/WB controller for the RF/ALU datapath.
// Decodes a 16-bit instruction from a combinational ROM and drives the datapath selects.
module rf_alu_sequencer #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [15:0]     instr,
   input  logic            N_in,
   input  logic            Z_in,
   input  logic            V_in,
   input  logic            C_in,
   output logic [PC_W-1:0] pc,
   output logic            RF_en,
   output logic [2:0]      RF_addr,
   output logic [2:0]      read_A,
   output logic [2:0]      read_B,
   output logic            add_or_sub,
   output logic            out_imm,
   output logic [15:0]     ext_B_data,
   output logic            LHI,
   output logic            LLI,
   output logic            ctro_outR,
   output logic [3:0]      flags,
   output logic            busy,
   output logic            halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [3:0]      flags_q, flags_d;

   logic [4:0]  op;
   logic [2:0]  rd, ra, rb;
   logic [15:0] imm5_x, imm8_x;

   assign op     = ir_q[15:11];
   assign rd     = ir_q[10:8];
   assign ra     = ir_q[7:5];
   assign rb     = ir_q[4:2];
   assign imm5_x = {{11{ir_q[4]}}, ir_q[4:0]};
   assign imm8_x = {8'h00, ir_q[7:0]};

   logic op_add, op_sub, op_addi, op_subi;
   logic op_lhi, op_lli, op_cmp, op_out;
   logic op_beq, op_bne, op_jmp, op_hlt;
   logic writer, sets_flags, br_taken;

   assign op_add  = (op == 5'b00000);
   assign op_sub  = (op == 5'b00001);
   assign op_addi = (op == 5'b00010);
   assign op_subi = (op == 5'b00011);
   assign op_lhi  = (op == 5'b00100);
   assign op_lli  = (op == 5'b00101);
   assign op_cmp  = (op == 5'b00110);
   assign op_out  = (op == 5'b00111);
   assign op_beq  = (op == 5'b01000);
   assign op_bne  = (op == 5'b01001);
   assign op_jmp  = (op == 5'b01010);
   assign op_hlt  = (op == 5'b11111);

   assign writer     = op_add | op_sub | op_addi | op_subi
                     | op_lhi | op_lli;
   assign sets_flags = op_add | op_sub | op_addi | op_subi
                     | op_cmp;
   assign br_taken   = op_jmp
                     | (op_beq &  flags_q[2])
                     | (op_bne & ~flags_q[2]);

   logic in_exec, in_wb;
   assign in_exec = (state_q == S_EXEC);
   assign in_wb   = (state_q == S_WB);

   // Sequencer next state: fetch, execute, optional write-back, halt.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      flags_d = flags_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end
         end
         S_FETCH: begin
            ir_d    = instr;
            pc_d    = pc_q + PC_W'(1);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (sets_flags) begin
               flags_d = {N_in, Z_in, V_in, C_in};
            end
            if (br_taken) begin
               pc_d = PC_W'(ir_q[7:0]);
            end
            if (writer) begin
               state_d = S_WB;
            end else if (op_hlt) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
         end
         S_HALT: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = '0;
               flags_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, pc, IR and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
      end
   end

   // Datapath selects held steady over EXEC and WB; write only in WB.
   always_comb begin
      read_A     = 3'd0;
      read_B     = 3'd0;
      add_or_sub = 1'b0;
      out_imm    = 1'b0;
      ext_B_data = 16'h0000;
      LHI        = 1'b0;
      LLI        = 1'b0;
      ctro_outR  = 1'b0;
      if (in_exec || in_wb) begin
         unique case (1'b1)
            op_add, op_sub: begin
               read_A     = ra;
               read_B     = rb;
               add_or_sub = op_sub;
            end
            op_addi, op_subi: begin
               read_A     = ra;
               out_imm    = 1'b1;
               ext_B_data = imm5_x;
               add_or_sub = op_subi;
            end
            op_lhi: begin
               read_A     = rd;
               LHI        = 1'b1;
               ext_B_data = imm8_x;
            end
            op_lli: begin
               LLI        = 1'b1;
               ext_B_data = imm8_x;
            end
            op_cmp: begin
               read_A     = ra;
               read_B     = rb;
               add_or_sub = 1'b1;
            end
            op_out: begin
               read_A    = ra;
               ctro_outR = in_exec;
            end
            default: begin
            end
         endcase
      end
      RF_en   = in_wb & writer;
      RF_addr = (in_wb & writer) ? rd : 3'd0;
   end

   assign pc     = pc_q;
   assign flags  = flags_q;
   assign busy   = (state_q == S_FETCH) || in_exec || in_wb;
   assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// tb_rf_alu_sequencer: datapath/ROM environment plus an instruction-level
// model that predicts every cycle of the sequencer's outputs.
module tb_rf_alu_sequencer;

   localparam logic [4:0] OP_ADD  = 5'h00;
   localparam logic [4:0] OP_SUB  = 5'h01;
   localparam logic [4:0] OP_ADDI = 5'h02;
   localparam logic [4:0] OP_SUBI = 5'h03;
   localparam logic [4:0] OP_LHI  = 5'h04;
   localparam logic [4:0] OP_LLI  = 5'h05;
   localparam logic [4:0] OP_CMP  = 5'h06;
   localparam logic [4:0] OP_OUT  = 5'h07;
   localparam logic [4:0] OP_BEQ  = 5'h08;
   localparam logic [4:0] OP_BNE  = 5'h09;
   localparam logic [4:0] OP_NOP  = 5'h0C;
   localparam logic [15:0] HLT    = 16'hF800;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] instr;
   logic        N_in, Z_in, V_in, C_in;
   logic [7:0]  pc;
   logic        RF_en;
   logic [2:0]  RF_addr, read_A, read_B;
   logic        add_or_sub, out_imm;
   logic [15:0] ext_B_data;
   logic        LHI, LLI, ctro_outR;
   logic [3:0]  flags;
   logic        busy, halted;

   rf_alu_sequencer #(.PC_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
      .N_in(N_in), .Z_in(Z_in), .V_in(V_in), .C_in(C_in),
      .pc(pc), .RF_en(RF_en), .RF_addr(RF_addr),
      .read_A(read_A), .read_B(read_B),
      .add_or_sub(add_or_sub), .out_imm(out_imm),
      .ext_B_data(ext_B_data), .LHI(LHI), .LLI(LLI),
      .ctro_outR(ctro_outR), .flags(flags),
      .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   // ROM and datapath environment
   logic [15:0] rom [256];
   assign instr = rom[pc];

   logic [15:0] rf [8] = '{default: 16'h0000};
   logic [15:0] dp_a, dp_b, dp_bx, dp_s;
   logic        dp_co;

   always_comb begin
      dp_a  = rf[read_A];
      dp_b  = out_imm ? ext_B_data : rf[read_B];
      dp_bx = add_or_sub ? ~dp_b : dp_b;
      {dp_co, dp_s} = {1'b0, dp_a} + {1'b0, dp_bx}
                    + {16'h0000, add_or_sub};
      if (LHI)
         dp_s = {ext_B_data[7:0], dp_a[7:0]};
      else if (LLI)
         dp_s = ext_B_data;
   end

   assign N_in = dp_s[15];
   assign Z_in = (dp_s == 16'h0000);
   assign V_in = (dp_a[15] == dp_bx[15]) && (dp_s[15] != dp_a[15]);
   assign C_in = dp_co ^ add_or_sub;

   always @(posedge clk)
      if (RF_en) rf[RF_addr] <= dp_s;

   // Expected-output vector
   typedef struct packed {
      logic [7:0]  pc;
      logic        busy;
      logic        halted;
      logic        rf_en;
      logic [2:0]  rf_addr;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic        aos;
      logic        oimm;
      logic [15:0] ext;
      logic        lhi;
      logic        lli;
      logic        ctro;
      logic [3:0]  flags;
   } exp_t;

   exp_t got, e_cur;
   assign got = {pc, busy, halted, RF_en, RF_addr, read_A, read_B,
                 add_or_sub, out_imm, ext_B_data, LHI, LLI,
                 ctro_outR, flags};

   exp_t        expq[$];
   exp_t        mq[$];
   logic [7:0]  mfetch[$];
   logic [15:0] mregs [8];
   logic [3:0]  mflags;

   int n_chk = 0;
   int n_fail = 0;
   int ctro_cnt;
   logic [2:0]  ctro_ra, lhi_ra;
   logic [15:0] lhi_ext, imm_seen;

   // Per-cycle compare against the model trace, plus event capture
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         e_cur = expq.pop_front();
         n_chk++;
         if (got !== e_cur) begin
            n_fail++;
            $display("FAIL cycle_trace t=%0t got=%h exp=%h",
                     $time, got, e_cur);
         end
      end
      if (ctro_outR) begin
         ctro_cnt++;
         ctro_ra = read_A;
      end
      if (LHI && !RF_en) begin
         lhi_ra  = read_A;
         lhi_ext = ext_B_data;
      end
      if (out_imm) imm_seen = ext_B_data;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", nm, act, req);
      end
   endtask

   function automatic logic [15:0] i_r(input logic [4:0] op,
      input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
      return {op, d, a, b, 2'b00};
   endfunction

   function automatic logic [15:0] i_8(input logic [4:0] op,
      input logic [2:0] d, input logic [7:0] imm);
      return {op, d, imm};
   endfunction

   function automatic logic [15:0] i_5(input logic [4:0] op,
      input logic [2:0] d, input logic [2:0] a, input logic [4:0] imm);
      return {op, d, a, imm};
   endfunction

   // Architectural ALU: {N,Z,V,C, result}; C means borrow on subtract
   function automatic logic [19:0] alu(input logic [15:0] a,
      input logic [15:0] b, input logic sub);
      logic [16:0] w;
      logic [15:0] r;
      logic        c, v;
      if (!sub) begin
         w = {1'b0, a} + {1'b0, b};
         r = w[15:0];
         c = w[16];
         v = (a[15] == b[15]) && (r[15] != a[15]);
      end else begin
         r = a - b;
         c = (a < b);
         v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      return {r[15], (r == 16'h0000), v, c, r};
   endfunction

   function automatic exp_t base(input logic [7:0] p,
                                 input logic [3:0] f);
      exp_t e;
      e = '0;
      e.pc = p;
      e.busy = 1'b1;
      e.flags = f;
      return e;
   endfunction

   // Instruction-level model: runs the ROM from pc=0 to HLT
   task automatic model_run();
      logic [7:0]  mpc, npc;
      logic [15:0] ir, a, b, r, sx;
      logic [4:0]  op;
      logic [2:0]  rd, ra, rb;
      logic [3:0]  nf;
      logic        wr, setf, done;
      exp_t        e;
      mq.delete();
      mfetch.delete();
      mpc = 8'h00;
      mflags = 4'h0;
      done = 1'b0;
      for (int k = 0; k < 64 && !done; k++) begin
         ir = rom[mpc];
         op = ir[15:11];
         rd = ir[10:8];
         ra = ir[7:5];
         rb = ir[4:2];
         sx = {{11{ir[4]}}, ir[4:0]};
         mq.push_back(base(mpc, mflags));
         mfetch.push_back(mpc);
         npc = mpc + 8'd1;
         e = base(npc, mflags);
         wr = 1'b0;
         setf = 1'b0;
         a = 16'h0;
         b = 16'h0;
         r = 16'h0;
         nf = mflags;
         case (op)
            OP_ADD, OP_SUB: begin
               e.ra = ra; e.rb = rb; e.aos = op[0];
               a = mregs[ra]; b = mregs[rb];
               wr = 1'b1; setf = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
               e.ra = ra; e.oimm = 1'b1; e.ext = sx;
               e.aos = op[0];
               a = mregs[ra]; b = sx;
               wr = 1'b1; setf = 1'b1;
            end
            OP_LHI: begin
               e.ra = rd; e.lhi = 1'b1;
               e.ext = {8'h00, ir[7:0]};
               r = {ir[7:0], mregs[rd][7:0]};
               wr = 1'b1;
            end
            OP_LLI: begin
               e.lli = 1'b1;
               e.ext = {8'h00, ir[7:0]};
               r = {8'h00, ir[7:0]};
               wr = 1'b1;
            end
            OP_CMP: begin
               e.ra = ra; e.rb = rb; e.aos = 1'b1;
               a = mregs[ra]; b = mregs[rb];
               setf = 1'b1;
            end
            OP_OUT: begin
               e.ra = ra; e.ctro = 1'b1;
            end
            OP_BEQ: if (mflags[2]) npc = ir[7:0];
            OP_BNE: if (!mflags[2]) npc = ir[7:0];
            5'h0A: npc = ir[7:0];
            5'h1F: done = 1'b1;
            default: ;
         endcase
         if (setf) {nf, r} = alu(a, b, e.aos);
         mq.push_back(e);
         if (setf) mflags = nf;
         if (wr) begin
            e.rf_en = 1'b1;
            e.rf_addr = rd;
            e.flags = mflags;
            mq.push_back(e);
            mregs[rd] = r;
         end
         if (done) begin
            e = base(mpc + 8'd1, mflags);
            e.busy = 1'b0;
            e.halted = 1'b1;
            mq.push_back(e);
         end
         mpc = npc;
      end
   endtask

   task automatic clr_rom();
      for (int i = 0; i < 256; i++) rom[i] = HLT;
   endtask

   // Pulse start, replay model trace, wait (bounded) for HALT
   task automatic run_prog(input int pulse_at, output int cycles);
      model_run();
      ctro_cnt = 0;
      ctro_ra = 3'd0;
      lhi_ra = 3'd0;
      lhi_ext = 16'h0;
      imm_seen = 16'h0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      foreach (mq[i]) expq.push_back(mq[i]);
      cycles = 0;
      while (!halted && cycles < 500) begin
         @(posedge clk);
         #1;
         cycles++;
         start = (cycles == pulse_at);
      end
      start = 1'b0;
      chk("halted", halted, 1);
      @(negedge clk);
      #1;
      chk("trace_drained", expq.size(), 0);
      expq.delete();
      for (int i = 0; i < 8; i++)
         chk("rf_vs_model", rf[i], mregs[i]);
   endtask

   int cyc;
   logic [15:0] old6;
   logic [4:0]  br_op [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
   logic [2:0]  br_rb [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
   logic [7:0]  br_pc [4] = '{8'h21, 8'h03, 8'h03, 8'h21};
   logic [7:0]  br_f2 [4] = '{8'h20, 8'h02, 8'h02, 8'h20};

   initial begin
      clr_rom();
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
      #2;
      chk("reset_outputs", got, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_not_busy", {busy, halted}, 2'b00);

      // Basic ALU sequence
      clr_rom();
      rom[0] = i_8(OP_LLI, 3'd1, 8'h05);
      rom[1] = i_8(OP_LLI, 3'd2, 8'h03);
      rom[2] = i_r(OP_SUB, 3'd3, 3'd1, 3'd2);
      rom[3] = i_r(OP_OUT, 3'd0, 3'd3, 3'd0);
      run_prog(-1, cyc);
      chk("t1_cycles", cyc, 13);
      chk("t1_r3", rf[3], 16'h0002);
      chk("t1_ctro_cnt", ctro_cnt, 1);
      chk("t1_ctro_ra", ctro_ra, 3'd3);
      chk("t1_flags", flags, 4'b0000);

      // LHI/LLI pair
      clr_rom();
      rom[0] = i_8(OP_LLI, 3'd4, 8'h34);
      rom[1] = i_8(OP_LHI, 3'd4, 8'h12);
      run_prog(-1, cyc);
      chk("t2_r4", rf[4], 16'h1234);
      chk("t2_lhi_ra", lhi_ra, 3'd4);
      chk("t2_lhi_imm", lhi_ext[7:0], 8'h12);

      // Branches on Z after CMP
      for (int t = 0; t < 4; t++) begin
         clr_rom();
         rom[0] = i_r(OP_CMP, 3'd0, 3'd1, br_rb[t]);
         rom[1] = i_8(br_op[t], 3'd0, 8'h20);
         run_prog(-1, cyc);
         chk("t3_model_fetch", mfetch[2], br_f2[t]);
         chk("t3_halt_pc", pc, br_pc[t]);
      end

      // Sign-extended immediate, with a start pulse while busy
      clr_rom();
      rom[0] = i_5(OP_ADDI, 3'd5, 3'd0, 5'h1F);
      run_prog(2, cyc);
      chk("t4_r5", rf[5], 16'hFFFF);
      chk("t4_imm", imm_seen, 16'hFFFF);
      chk("t4_flags", flags, 4'b1000);
      chk("t4_cycles", cyc, 5);

      // PC wrap through 0xFF
      clr_rom();
      rom[0]    = i_8(OP_BNE, 3'd0, 8'hFE);
      rom[8'hFE] = i_r(OP_CMP, 3'd0, 3'd0, 3'd0);
      rom[8'hFF] = {OP_NOP, 11'd0};
      run_prog(-1, cyc);
      chk("t5_fetch_ff", mfetch[2], 8'hFF);
      chk("t5_fetch_wrap", mfetch[3], 8'h00);
      chk("t5_halt_pc", pc, 8'h02);

      // Reset during write-back
      clr_rom();
      rom[0] = i_5(OP_SUBI, 3'd6, 3'd0, 5'd1);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int w = 0; w < 20 && !RF_en; w++) @(negedge clk);
      chk("t6_wb_reached", RF_en, 1);
      chk("t6_flags_pre", flags, 4'b1001);
      old6 = rf[6];
      rst_n = 1'b0;
      #1;
      chk("t6_rf_en", RF_en, 0);
      chk("t6_pc", pc, 8'h00);
      chk("t6_flags", flags, 4'h0);
      chk("t6_state", {busy, halted}, 2'b00);
      @(posedge clk);
      #1;
      chk("t6_no_write", rf[6], old6);
      @(negedge clk);
      rst_n = 1'b1;

      // Restart from IDLE after reset
      clr_rom();
      rom[0] = i_r(OP_ADD, 3'd7, 3'd1, 3'd2);
      run_prog(-1, cyc);
      chk("t7_r7", rf[7], 16'h0008);
      chk("t7_cycles", cyc, 5);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
